// File: rtl/cla_pipe_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder:
// default geometry, stage-count derivation and a geometry sanity check.
package cla_pipe_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_GROUP = 8;

    // One pipeline stage per lookahead group.
    function automatic int unsigned nstage(input int unsigned width, input int unsigned group);
        return width / group;
    endfunction

    // Geometry is legal when groups tile the operand exactly and hold at least 2 bits.
    function automatic bit cfg_ok(input int unsigned width, input int unsigned group);
        return (group >= 2) && ((width % group) == 0);
    endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead block. Every internal carry is
// formed from prefix generate/propagate terms and the group carry-in, so no
// carry ripples bit to bit. Group-level p/g are exported for the next level.
module cla_group #(
    parameter int unsigned GROUP = 8
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             co,
    output logic             p,
    output logic             g
);

    logic [GROUP-1:0] pb;
    logic [GROUP-1:0] gb;
    logic [GROUP-1:0] gp;
    logic [GROUP-1:0] pp;
    logic [GROUP:0]   c;

    // Bit p/g, prefix p/g over bits [i:0], then each carry as G[i:0] | P[i:0]&ci.
    always_comb begin
        pb    = a ^ b;
        gb    = a & b;
        gp    = '0;
        pp    = '0;
        c     = '0;
        gp[0] = gb[0];
        pp[0] = pb[0];
        for (int unsigned i = 1; i < GROUP; i++) begin
            gp[i] = gb[i] | (pb[i] & gp[i-1]);
            pp[i] = pb[i] & pp[i-1];
        end
        c[0] = ci;
        for (int unsigned i = 0; i < GROUP; i++) begin
            c[i+1] = gp[i] | (pp[i] & ci);
        end
        s  = pb ^ c[GROUP-1:0];
        co = c[GROUP];
        p  = pp[GROUP-1];
        g  = gp[GROUP-1];
    end

endmodule

// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Register 0 latches the effective operands and carry-in; register k+1
// holds the result of adding group k. Each register carries full-width
// operand and partial-sum vectors: upper operand groups ride forward
// (skew) and finished lower sum groups ride along (deskew), so the whole
// sum leaves register NSTAGE together. Unused low operand bits and
// not-yet-computed sum bits are dead logic and fold away.
module cla_pipe
    import cla_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned GROUP = DEF_GROUP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSTAGE = nstage(WIDTH, GROUP);
    localparam int unsigned MSB    = WIDTH - 1;

    if (!cfg_ok(WIDTH, GROUP)) begin : g_cfg_bad
        $error("cla_pipe: WIDTH must be a multiple of GROUP and GROUP must be >= 2");
    end

    logic             v_q [NSTAGE+1];
    logic             c_q [NSTAGE+1];
    logic [WIDTH-1:0] a_q [NSTAGE+1];
    logic [WIDTH-1:0] b_q [NSTAGE+1];
    logic [WIDTH-1:0] s_q [NSTAGE+1];

    logic [GROUP-1:0] grp_s  [NSTAGE];
    logic             grp_co [NSTAGE];
    logic             grp_p  [NSTAGE];
    logic             grp_g  [NSTAGE];
    logic             c_nxt  [NSTAGE];
    logic [WIDTH-1:0] s_nxt  [NSTAGE];

    logic advance;

    assign advance   = !v_q[NSTAGE] || out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[NSTAGE];
    assign s         = s_q[NSTAGE];
    assign cout      = c_q[NSTAGE];
    assign ovf       = (a_q[NSTAGE][MSB] == b_q[NSTAGE][MSB]) &&
                       (s_q[NSTAGE][MSB] != a_q[NSTAGE][MSB]);

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam logic [WIDTH-1:0] GMASK = WIDTH'({GROUP{1'b1}}) << (k * GROUP);

        cla_group #(.GROUP(GROUP)) u_grp (
            .a  (a_q[k][k*GROUP +: GROUP]),
            .b  (b_q[k][k*GROUP +: GROUP]),
            .ci (c_q[k]),
            .s  (grp_s[k]),
            .co (grp_co[k]),
            .p  (grp_p[k]),
            .g  (grp_g[k])
        );

        // Inter-stage carries use the group p/g lookahead term; the final
        // group's own carry-out becomes cout. Both forms are equivalent.
        if (k == NSTAGE - 1) begin : g_last
            assign c_nxt[k] = grp_co[k];
        end else begin : g_mid
            assign c_nxt[k] = grp_g[k] | (grp_p[k] & c_q[k]);
        end

        assign s_nxt[k] = (s_q[k] & ~GMASK) | (WIDTH'(grp_s[k]) << (k * GROUP));
    end

    // Stage registers and valid chain: clear on reset, shift together on advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i <= NSTAGE; i++) begin
                v_q[i] <= 1'b0;
                c_q[i] <= 1'b0;
                a_q[i] <= '0;
                b_q[i] <= '0;
                s_q[i] <= '0;
            end
        end else if (advance) begin
            v_q[0] <= in_valid;
            c_q[0] <= sub | cin;
            a_q[0] <= a;
            b_q[0] <= sub ? ~b : b;
            s_q[0] <= '0;
            for (int unsigned k = 0; k < NSTAGE; k++) begin
                v_q[k+1] <= v_q[k];
                c_q[k+1] <= c_nxt[k];
                a_q[k+1] <= a_q[k];
                b_q[k+1] <= b_q[k];
                s_q[k+1] <= s_nxt[k];
            end
        end
    end

endmodule
